// File: rtl/rope_solver.sv
// Rope physics core: gravity plus iterative length relaxation over a chain of nodes,
// processed one node per cycle through a single shared clamp datapath.
module rope_solver #(
    parameter int N    = 20,
    parameter int W    = 10,
    parameter int SEG  = 8,
    parameter int GRAV = 1,
    parameter int ITER = 2,
    parameter int XMAX = 639,
    parameter int YMAX = 479
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   mouse_x,
    input  logic [W-1:0]   mouse_y,
    input  logic           pin_en,
    input  logic [W-1:0]   pin_x,
    input  logic [W-1:0]   pin_y,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] nodes_x,
    output logic [N*W-1:0] nodes_y
);

    localparam int IW = $clog2(N);
    localparam int TW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GRAV = 3'd1;
    localparam logic [2:0] S_FWD  = 3'd2;
    localparam logic [2:0] S_BWD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IW-1:0]      ONE         = IW'(1);
    localparam logic [IW-1:0]      LAST        = IW'(N - 1);
    localparam logic [IW-1:0]      SECOND_LAST = IW'(N - 2);
    localparam logic [TW-1:0]      ITER_LAST   = TW'(ITER - 1);
    localparam logic [W-1:0]       XMAX_W      = W'(XMAX);
    localparam logic [W-1:0]       YMAX_W      = W'(YMAX);
    localparam logic signed [W+1:0] SEG_S      = (W+2)'(SEG);

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [TW-1:0] iter;
    logic          pinned;
    logic [W-1:0]  node_x [N];
    logic [W-1:0]  node_y [N];

    logic [IW-1:0] ref_idx;
    logic [W-1:0]  new_x;
    logic [W-1:0]  new_y;
    logic [W:0]    grav_sum;
    logic [W-1:0]  grav_y;
    logic          fwd_end;

    function automatic logic [W-1:0] sat(input logic [W-1:0] v, input logic [W-1:0] m);
        return (v > m) ? m : v;
    endfunction

    // Pull cur to within SEG of rf on one axis, then saturate into [0, maxv].
    function automatic logic [W-1:0] clamp_axis(input logic [W-1:0] cur,
                                                input logic [W-1:0] rf,
                                                input logic [W-1:0] maxv);
        logic signed [W+1:0] c, r, m, d, res;
        c = $signed({2'b00, cur});
        r = $signed({2'b00, rf});
        m = $signed({2'b00, maxv});
        d = c - r;
        if (d > SEG_S)
            res = r + SEG_S;
        else if (d < -SEG_S)
            res = r - SEG_S;
        else
            res = c;
        if (res[W+1])
            return '0;
        else if (res > m)
            return maxv;
        else
            return res[W-1:0];
    endfunction

    always_comb begin
        ref_idx = '0;
        if (state == S_FWD)
            ref_idx = idx - ONE;
        else if (state == S_BWD)
            ref_idx = idx + ONE;
    end

    assign new_x    = clamp_axis(node_x[idx], node_x[ref_idx], XMAX_W);
    assign new_y    = clamp_axis(node_y[idx], node_y[ref_idx], YMAX_W);
    assign grav_sum = {1'b0, node_y[idx]} + (W+1)'(GRAV);
    assign grav_y   = (grav_sum > {1'b0, YMAX_W}) ? YMAX_W : grav_sum[W-1:0];
    assign fwd_end  = pinned ? (idx == SECOND_LAST) : (idx == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            iter   <= '0;
            pinned <= 1'b0;
            for (int i = 0; i < N; i++) begin
                node_x[i] <= '0;
                node_y[i] <= W'(i * SEG);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pinned    <= pin_en;
                        node_x[0] <= sat(mouse_x, XMAX_W);
                        node_y[0] <= sat(mouse_y, YMAX_W);
                        if (pin_en) begin
                            node_x[N-1] <= sat(pin_x, XMAX_W);
                            node_y[N-1] <= sat(pin_y, YMAX_W);
                        end
                        idx   <= ONE;
                        iter  <= '0;
                        state <= S_GRAV;
                    end
                end
                S_GRAV: begin
                    // A pinned tail keeps its position but still costs a cycle.
                    if (!(pinned && idx == LAST))
                        node_y[idx] <= grav_y;
                    if (idx == LAST) begin
                        idx   <= ONE;
                        state <= S_FWD;
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                S_FWD: begin
                    node_x[idx] <= new_x;
                    node_y[idx] <= new_y;
                    if (fwd_end) begin
                        if (pinned) begin
                            idx   <= SECOND_LAST;
                            state <= S_BWD;
                        end else if (iter == ITER_LAST) begin
                            state <= S_DONE;
                        end else begin
                            iter <= iter + TW'(1);
                            idx  <= ONE;
                        end
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                S_BWD: begin
                    node_x[idx] <= new_x;
                    node_y[idx] <= new_y;
                    if (idx == ONE) begin
                        if (iter == ITER_LAST) begin
                            state <= S_DONE;
                        end else begin
                            iter  <= iter + TW'(1);
                            idx   <= ONE;
                            state <= S_FWD;
                        end
                    end else begin
                        idx <= idx - ONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign nodes_x[g*W +: W] = node_x[g];
        assign nodes_y[g*W +: W] = node_y[g];
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_rope_solver.sv
// Scoreboard bench for rope_solver: expected frames are queued by the driver and
// compared by a monitor whenever done pulses.
module tb_rope_solver;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   mouse_x, mouse_y;
    logic           pin_en;
    logic [W-1:0]   pin_x, pin_y;
    logic           busy, done;
    logic [N*W-1:0] nodes_x, nodes_y;

    always #5 clk = ~clk;

    rope_solver #(
        .N(N), .W(W), .SEG(8), .GRAV(1), .ITER(1), .XMAX(639), .YMAX(479)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mouse_x(mouse_x), .mouse_y(mouse_y),
        .pin_en(pin_en), .pin_x(pin_x), .pin_y(pin_y),
        .busy(busy), .done(done),
        .nodes_x(nodes_x), .nodes_y(nodes_y)
    );

    typedef struct {
        logic [N*W-1:0] ex;
        logic [N*W-1:0] ey;
        int             cycles;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   busy_cnt = 0;

    function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles of the current frame and scores it on done.
    always @(negedge clk) begin
        if (busy)
            busy_cnt++;
        else
            busy_cnt = 0;
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, "_x"}, nodes_x, mon_e.ex);
                checkOutput({mon_e.name, "_y"}, nodes_y, mon_e.ey);
                checkOutput({mon_e.name, "_cycles"}, busy_cnt, mon_e.cycles);
            end
        end
    end

    task automatic doReset(input int cycles);
        reset = 1'b1;
        start = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int mx, input int my, input logic pe, input int px, input int py);
        mouse_x = W'(mx);
        mouse_y = W'(my);
        pin_en  = pe;
        pin_x   = W'(px);
        pin_y   = W'(py);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
    endtask

    task automatic waitFrames(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=expired required=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int dc;
        reset   = 1'b1;
        start   = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        pin_en  = 1'b0;
        pin_x   = '0;
        pin_y   = '0;
        doReset(2);

        checkOutput("reset_x", nodes_x, '0);
        checkOutput("reset_y", nodes_y, pack4(0, 8, 16, 24));
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);

        exp_q.push_back('{pack4(100, 92, 84, 76), pack4(0, 8, 16, 24), 7, "unpinned"});
        applyStimulus(100, 0, 1'b0, 0, 0);
        waitFrames("unpinned");

        doReset(1);
        exp_q.push_back('{pack4(300, 16, 8, 0), pack4(0, 8, 16, 24), 8, "pinned"});
        applyStimulus(300, 0, 1'b1, 0, 24);
        waitFrames("pinned");

        doReset(1);
        exp_q.push_back('{pack4(639, 631, 623, 615), pack4(479, 471, 463, 455), 7, "saturate"});
        applyStimulus(1023, 1023, 1'b0, 0, 0);
        checkOutput("sat_node0_x", nodes_x[W-1:0], 639);
        checkOutput("sat_node0_y", nodes_y[W-1:0], 479);
        waitFrames("saturate");

        // Inputs churn while busy; the clean second frame starts right after done.
        doReset(1);
        exp_q.push_back('{pack4(100, 92, 84, 76), pack4(0, 8, 16, 24), 7, "ignore_a"});
        exp_q.push_back('{pack4(100, 92, 84, 76), pack4(0, 8, 16, 24), 7, "ignore_b"});
        applyStimulus(100, 0, 1'b0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            mouse_x = W'(500 + c);
            mouse_y = W'(400);
            pin_en  = 1'b1;
            pin_x   = W'(5);
            pin_y   = W'(5);
            start   = (c % 2 == 0);
            @(posedge clk);
            #1;
        end
        mouse_x = W'(100);
        mouse_y = W'(0);
        pin_en  = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_after_done", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("next_accept_busy", busy, 1);
        waitFrames("ignore");

        doReset(1);
        applyStimulus(200, 50, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        dc = done_count;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_x", nodes_x, '0);
        checkOutput("abort_y", nodes_y, pack4(0, 8, 16, 24));
        checkOutput("abort_busy", busy, 0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_count, dc);

        mouse_x = W'(50);
        mouse_y = W'(50);
        reset   = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_wins_busy", busy, 0);
        checkOutput("reset_wins_x", nodes_x, '0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rope_solver.md
# rope_solver

Parametrised rope physics engine: a chain of N nodes with W-bit screen coordinates, head driven by the mouse, optional pinned tail, per-frame gravity and multi-iteration length relaxation. It is the next-generation rope core, driven once per video frame by the frame controller; the renderer samples the packed node vectors on `done`. Processing is sequential, one node per cycle, so only one clamp datapath is required.

## Interface
- N, 20, node count (N ≥ 3; (N-1)·SEG ≤ YMAX)
- W, 10, coordinate width
- SEG, 8, maximum per-axis segment length
- GRAV, 1, y increment per frame for free nodes
- ITER, 2, relaxation iterations per frame (≥ 1)
- XMAX, 639, maximum x coordinate
- YMAX, 479, maximum y coordinate

Ports:
- clk  in  1  clock; the block uses this single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  frame-update request, sampled only in IDLE
- mouse_x, mouse_y  in  W  head target
- pin_en  in  1  pin the tail node for this frame
- pin_x, pin_y  in  W  tail pin position
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high only in DONE
- nodes_x, nodes_y  out  N·W  node i at bits [i·W +: W]

## Operation
- Reset: node i = (0, i·SEG); state IDLE; busy = 0, done = 0.
- IDLE & start (accept edge):
  - latch pin_en;
  - write node 0 = (min(mouse_x, XMAX), min(mouse_y, YMAX));
  - if pin_en, write node N-1 = (min(pin_x, XMAX), min(pin_y, YMAX));
  - go to GRAV.
- Inputs other than reset are ignored after the accept edge until the block returns to IDLE.
- GRAV, N-1 cycles, i = 1..N-1: y = min(y + GRAV, YMAX). When pinned, node N-1 is left unchanged but its cycle is still spent.
- FWD, i = 1..N-1 (unpinned) or 1..N-2 (pinned): clamp node i to node i-1, using the already-updated predecessor.
- BWD, pinned only, i = N-2 downto 1: clamp node i to node i+1.
- Iterations: FWD (+BWD) repeats ITER times, then DONE.
- DONE, one cycle: done = 1, then IDLE.
- Clamp, applied per axis independently:
  - d = cur − ref, computed as signed W+1 bits;
  - d > SEG → cur = ref + SEG; d < −SEG → cur = ref − SEG; otherwise unchanged;
  - the result saturates to [0, XMAX] for x and [0, YMAX] for y.
- Node 0, and node N-1 when pinned, are never modified by GRAV, FWD or BWD.
- Synchronous reset in any state restores reset values in the next cycle. No done pulse is produced for an aborted frame.

## Timing
- Node registers update at the edge ending each processing cycle. Intermediate values are visible on nodes_x and nodes_y; consumers sample only when done = 1.
- busy rises in the cycle after the accept edge.
- busy-high cycles, DONE included:
  - unpinned: (N-1) + ITER·(N-1) + 1;
  - pinned: (N-1) + ITER·2·(N-2) + 1.
- done is high in the last busy cycle. The block returns to IDLE the following cycle, and a start in that cycle is accepted.
- start held high: one frame per IDLE visit, back-to-back.
- start and reset asserted together: reset wins.

## Test plan
All scenarios use N=4, W=10, SEG=8, GRAV=1, ITER=1 unless stated otherwise.

- Reset → nodes_x = 0 for all nodes, nodes_y = {0,8,16,24} for nodes 0..3; busy = 0, done = 0.
- From reset, start with mouse = (100,0), pin_en = 0 → busy for 7 cycles, done in the 7th. Final x = {100,92,84,76}, y = {0,8,16,24}.
- From reset, start with mouse = (300,0), pin_en = 1, pin = (0,24) → busy for 8 cycles. Final x = {300,16,8,0}, y = {0,8,16,24}.
- From reset, start with mouse = (1023,1023) → node 0 = (639,479). Final x = {639,631,623,615}, y = {479,471,463,455}.
- During busy, toggle start and change mouse and pin → no effect on the result or the cycle count. The next start is accepted in the cycle after done.
- Assert reset for 1 cycle during GRAV → next cycle all nodes at reset values, busy = 0, and no done pulse.
